// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer for a 1-cycle synchronous-read instruction memory.
// Optional perf counters (fetch_count/stall_count) enabled by FETCH_PERF_CNT_EN.
module imem_fetch_sequencer #(
  parameter int RESET_PC  = 0,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instruction,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC) & PC_MASK;

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_valid;

  logic              redir;
  logic              hold;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic [ADDR_W-1:0] tgt_pc_inc;

  assign redir        = redirect_valid && (state != BOOT);
  // Holding the output also holds the in-flight word: the memory re-reads it.
  assign hold         = stall && instr_valid;
  assign tgt_pc       = redirect_pc & PC_MASK;
  assign fetch_pc_inc = (fetch_pc + 1'b1) & PC_MASK;
  assign tgt_pc_inc   = (tgt_pc + 1'b1) & PC_MASK;

  always_comb begin
    imem_addr = fetch_pc;
    if (redir)     imem_addr = tgt_pc;
    else if (hold) imem_addr = inflight_pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      fetch_pc       <= PC_INIT;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
    end else begin
      case (state)
        BOOT: begin
          inflight_valid <= 1'b1;
          inflight_pc    <= fetch_pc;
          fetch_pc       <= fetch_pc_inc;
          state          <= RUN;
        end
        RUN, STALL, HALTED: begin
          if (redir) begin
            // Squash whatever is on the output and in flight; target lands at t+2.
            instr_valid    <= 1'b0;
            inflight_valid <= 1'b1;
            inflight_pc    <= tgt_pc;
            fetch_pc       <= tgt_pc_inc;
            state          <= halt ? HALTED : RUN;
          end else if (hold) begin
            state <= STALL;
          end else begin
            instr_valid    <= inflight_valid;
            instr          <= imem_instruction;
            instr_pc       <= inflight_pc;
            inflight_valid <= !halt;
            inflight_pc    <= fetch_pc;
            if (!halt) fetch_pc <= fetch_pc_inc;
            state          <= halt ? HALTED : RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_valid && !stall && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (instr_valid && stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized bench for imem_fetch_sequencer against an in-flight-queue model.
// Memory word k holds k+100; counters checked when FETCH_PERF_CNT_EN is defined.
module tb_imem_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  imem_fetch_sequencer dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr),
    .imem_instruction(imem_instruction), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous-read memory: word k = k+100.
  always @(posedge clock) imem_instruction <= 32'(imem_addr[7:0]) + 32'd100;

  int n_chk = 0;
  int n_pass = 0;
  bit run_chk = 0;

  // Reference model: words in flight as a queue of PCs, plus the visible output.
  bit          m_boot;
  int unsigned m_next;
  int unsigned pipe[$];
  bit          m_v;
  int unsigned m_opc;
  logic [31:0] m_fc, m_sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    m_boot = 1; m_next = 0; pipe.delete(); m_v = 0; m_opc = 0; m_fc = 0; m_sc = 0;
  endtask

  task automatic model_step(input bit s, input bit rv, input logic [31:0] rp, input bit h);
    if (m_v && !s && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (m_v && s && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (m_boot) begin
      pipe.push_back(m_next);
      m_next = (m_next + 1) % 256;
      m_boot = 0;
    end else if (rv) begin
      m_v = 0;
      pipe.delete();
      pipe.push_back(rp % 256);
      m_next = (rp % 256 + 1) % 256;
    end else if (!(s && m_v)) begin
      m_v = (pipe.size() != 0);
      if (m_v) m_opc = pipe.pop_front();
      if (!h) begin
        pipe.push_back(m_next);
        m_next = (m_next + 1) % 256;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit rv, input logic [31:0] rp, input bit h);
    stall = s; redirect_valid = rv; redirect_pc = rp; halt = h;
    @(posedge clock);
    model_step(s, rv, rp, h);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 32'd0, 0);
  endtask

  task automatic exp_out(input int unsigned pc);
    chk("lit_valid", 32'(instr_valid), 32'd1);
    chk("lit_pc", instr_pc, pc);
    chk("lit_instr", instr, pc + 100);
  endtask

  // Single compare process against the model, mid-cycle.
  always @(negedge clock) begin
    if (run_chk) begin
      chk("valid", 32'(instr_valid), 32'(m_v));
      if (m_v) begin
        chk("pc", instr_pc, m_opc);
        chk("instr", instr, m_opc + 100);
      end
      if (!reset || m_boot) chk("addr", imem_addr, m_next);
      else if (redirect_valid) chk("addr", imem_addr, redirect_pc % 256);
      else if (stall && m_v) begin
        if (pipe.size() != 0) chk("addr", imem_addr, pipe[0]);
      end else if (!halt) chk("addr", imem_addr, m_next);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("stall_count", stall_count, m_sc);
`endif
    end
  end

  initial begin
    bit h;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    run_chk = 1;
    reset = 1;

    // Boot and straight-line fetch.
    idle(); chk("boot_valid", 32'(instr_valid), 32'd0);
    idle(); exp_out(0);
    idle(); exp_out(1);
    idle(); exp_out(2);
    // Three stall cycles hold pc 2.
    repeat (3) begin cyc(1, 0, 32'd0, 0); exp_out(2); end
    idle(); exp_out(3);
    idle(); exp_out(4);
    idle(); exp_out(5);
    // Redirect to 20.
    cyc(0, 1, 32'd20, 0); chk("redir_squash", 32'(instr_valid), 32'd0);
    idle(); exp_out(20);
    idle(); exp_out(21);
    // Stall and redirect together.
    cyc(1, 1, 32'd40, 0); chk("sr_squash", 32'(instr_valid), 32'd0);
    idle(); exp_out(40);
    idle(); exp_out(41);
    // Wrap-around.
    cyc(0, 1, 32'd254, 0);
    idle(); exp_out(254);
    idle(); exp_out(255);
    idle(); exp_out(0);
    idle(); exp_out(1);
    // Upper redirect bits are masked: 0x310 -> 0x10.
    cyc(0, 1, 32'h0000_0310, 0);
    idle(); exp_out(16);
    // Halt drains one word, then bubbles; release resumes at 18.
    cyc(0, 0, 32'd0, 1); exp_out(17);
    cyc(0, 0, 32'd0, 1); chk("halt_drain", 32'(instr_valid), 32'd0);
    idle(); chk("halt_resume", 32'(instr_valid), 32'd0);
    idle(); exp_out(18);

    // Random phase.
    h = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) h = !h;
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, h);
    end

    // Asynchronous reset mid-run.
    #2 reset = 0;
    #1;
    model_reset();
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fc", fetch_count, 32'd0);
    chk("arst_sc", stall_count, 32'd0);
`endif
    stall = 0; redirect_valid = 0; halt = 0;
    @(posedge clock); #1;
    reset = 1;
    idle(); idle(); exp_out(0);
    repeat (10) idle();
    repeat (4) cyc(1, 0, 32'd0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_fetch_count", fetch_count, 32'd10);
    chk("lit_stall_count", stall_count, 32'd4);
`endif
    h = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 14) == 0) h = !h;
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, h);
    end
    run_chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
Fetch-side controller for the synchronous-read instruction memory (256 words, one-cycle read latency, word-indexed address). It generates the word address every cycle and tracks the in-flight read. It registers the returned instruction with its PC toward decode. It absorbs decode stalls without losing a word, squashes wrong-path reads on a branch/jump redirect, and supports halting fetch.

Parameters:
- RESET_PC, 0, first word address fetched after reset.
- MEM_DEPTH, 256, instruction memory depth in words; PC wraps modulo MEM_DEPTH (power of 2).
- ADDR_W, 32, width of address and PC buses.

Ports:
- clock  in  1  rising-edge clock, shared with instruction memory.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  word address to instruction memory.
- imem_instruction  in  32  memory read data; valid one cycle after imem_addr.
- stall  in  1  decode cannot accept; hold output.
- redirect_valid  in  1  branch/jump/call/ret taken; one-cycle pulse.
- redirect_pc  in  ADDR_W  redirect target word address.
- halt  in  1  level; stop issuing new fetches.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  32  fetched instruction (registered).
- instr_pc  out  ADDR_W  word address of instr (registered).

Behaviour:
Reset values (async, while reset = 0):
- fetch_pc = RESET_PC; inflight_valid = 0; inflight_pc = 0.
- instr_valid = 0, instr = 0, instr_pc = 0; state = BOOT.
- imem_addr = RESET_PC.

Latency:
- Address presented in cycle t; data on imem_instruction in t+1; instr/instr_valid registered in t+2.
- Steady-state throughput is one instruction per cycle.

Internal registers:
- fetch_pc: next address to issue.
- inflight_pc and inflight_valid: describe the word currently on imem_instruction.

States and transitions:
- BOOT: one cycle after reset release.
  - imem_addr = fetch_pc; inflight <= {1, fetch_pc}; fetch_pc <= fetch_pc+1; go to RUN.
- RUN: output regs <= {inflight_valid, imem_instruction, inflight_pc}.
  - imem_addr = fetch_pc; inflight <= {!halt, fetch_pc}.
  - fetch_pc advances by 1 unless halt.
  - stall with instr_valid=1 -> STALL. halt -> HALTED.
- STALL: output regs hold.
  - imem_addr = inflight_pc, so the memory re-reads the unconsumed word; fetch_pc and inflight hold.
  - When stall drops, behave as RUN in the same cycle.
- HALTED: no new issue; inflight drains into the output regs, then inflight_valid = 0.
  - halt drops -> RUN from the held fetch_pc.

Redirect (any state except BOOT, top priority):
- imem_addr = redirect_pc; inflight <= {1, redirect_pc}; fetch_pc <= redirect_pc+1.
- instr_valid <= 0 (squashes the wrong-path word); state -> RUN.
- The target appears on instr at t+2.
- redirect together with stall: redirect wins, and the squash overrides the stall hold.
- redirect together with halt: the target word is still fetched, then HALTED.
- redirect_valid during BOOT is ignored.

Wrap-around:
- fetch_pc = MEM_DEPTH-1 increments to 0.
- redirect_pc is masked to log2(MEM_DEPTH) bits; upper bits of imem_addr are 0.

Stall without a valid output does not freeze anything; bubbles flow.

Reset asserted mid-operation: everything returns to reset values immediately; no partial output.

Optional Feature:
Macro FETCH_PERF_CNT_EN.

When defined, add two outputs:
- fetch_count  out  32: increments each cycle a valid instruction leaves the output regs (instr_valid=1, stall=0).
- stall_count  out  32: increments each cycle with stall=1 and instr_valid=1.
- Both reset to 0 and saturate at 32'hFFFFFFFF.

When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Release reset, memory word k = k+100, no stall -> instr_pc 0,1,2,3 with instr 100,101,102,103; first instr_valid 2 cycles after BOOT.
- Stall for 3 cycles while instr_pc=2 -> instr stays 102 for 4 cycles total; next outputs are pc 3 (103), then 4 (104), with no skip or duplicate.
- redirect_valid with redirect_pc=20 while instr_pc=5 -> next cycle instr_valid=0; then instr_pc 20 (120), 21 (121).
- Stall and redirect in the same cycle (target 40) -> redirect wins; instr_pc=40 valid 2 cycles later.
- Start at fetch_pc=254 with no stall -> instr_pc sequence 254, 255, 0, 1.
- With FETCH_PERF_CNT_EN: 10 free-running fetches plus 4 stall cycles -> fetch_count=10, stall_count=4; assert reset mid-run -> all outputs 0 asynchronously.
